// File: rtl/if_fetch.sv
// if_fetch: THCO-MIPS instruction-fetch stage with IF/ID pipeline register.
// One outstanding req/ack fetch at a time, one branch delay slot, bubbles carry NOP_INST.
module if_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              fetch_busy_o
);

  typedef enum logic {S_FETCH, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic                act_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                redir_v_q, redir_v_d;
  logic [ADDR_W-1:0]   redir_addr_q, redir_addr_d;
  logic [ADDR_W-1:0]   hold_pc_q;
  logic [INST_W-1:0]   hold_inst_q;
  logic                hold_we;
  logic [ADDR_W-1:0]   pc_o_q, pc_o_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                vld_q, vld_d;

  logic                complete;
  logic                take;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   next_pc;

  // act_q keeps req low for the first cycle after reset release
  assign imem_req_o   = (state_q == S_FETCH) & act_q;
  assign imem_addr_o  = pc_q;
  assign complete     = imem_req_o & imem_ack_i;
  assign take         = branch_flag_i & vld_q & ~stall_i;
  assign pc_inc       = pc_q + ADDR_W'(1);
  assign next_pc      = take ? branch_addr_i : (redir_v_q ? redir_addr_q : pc_inc);
  assign fetch_busy_o = imem_req_o & ~imem_ack_i & rst;

  assign pc_o         = pc_o_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = vld_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_v_d    = redir_v_q;
    redir_addr_d = redir_addr_q;
    hold_we      = 1'b0;
    pc_o_d       = pc_o_q;
    inst_d       = inst_q;
    vld_d        = vld_q;
    case (state_q)
      S_FETCH: begin
        if (complete) begin
          pc_d      = next_pc;
          redir_v_d = 1'b0;
          if (stall_i) begin
            hold_we = 1'b1;
            state_d = S_HOLD;
          end else begin
            pc_o_d = pc_inc;
            inst_d = imem_rdata_i;
            vld_d  = 1'b1;
          end
        end else begin
          // Branch resolved while the delay-slot fetch is still outstanding
          if (take) begin
            redir_v_d    = 1'b1;
            redir_addr_d = branch_addr_i;
          end
          if (!stall_i) begin
            inst_d = NOP_INST;
            vld_d  = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          pc_o_d  = hold_pc_q;
          inst_d  = hold_inst_q;
          vld_d   = 1'b1;
          state_d = S_FETCH;
          // Buffered word is the delay slot; no fetch pending, so retarget the PC directly
          if (take) pc_d = branch_addr_i;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      act_q     <= 1'b0;
      pc_q      <= RESET_PC;
      redir_v_q <= 1'b0;
      pc_o_q    <= '0;
      inst_q    <= NOP_INST;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= 1'b1;
      pc_q      <= pc_d;
      redir_v_q <= redir_v_d;
      pc_o_q    <= pc_o_d;
      inst_q    <= inst_d;
      vld_q     <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    redir_addr_q <= redir_addr_d;
    if (hold_we) begin
      hold_inst_q <= imem_rdata_i;
      hold_pc_q   <= pc_inc;
    end
  end

endmodule
